// File: rtl/t05_ssdec_scan_ctrl.sv
// Scan controller for a bank of seven-segment digits sharing one hex decoder.
// Double-buffers the displayed value so a new value appears only at a frame boundary.
module t05_ssdec_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    lz_blank,
    output logic [3:0]              dec_in,
    output logic                    dec_enable,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done,
    output logic                    pend_valid
);

    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int VW   = 4 * NUM_DIGITS;

    localparam logic [1:0] OFF   = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] SHOW  = 2'd2;

    logic [1:0]            state, nstate;
    logic [IW-1:0]         idx, nidx;
    logic [CW-1:0]         cnt, ncnt;
    logic [VW-1:0]         active, nactive;
    logic [VW-1:0]         pending, npending;
    logic                  npv;
    logic                  frame_start;
    logic                  nfd;
    logic [NUM_DIGITS-1:0] hi_zero;
    logic [NUM_DIGITS-1:0] nsel;
    logic [3:0]            ndin;
    logic                  nden;

    always_comb begin
        nstate      = state;
        nidx        = idx;
        ncnt        = cnt;
        frame_start = 1'b0;
        nfd         = 1'b0;
        case (state)
            OFF: begin
                if (en) begin
                    nstate      = BLANK;
                    nidx        = '0;
                    ncnt        = '0;
                    frame_start = 1'b1;
                end
            end
            BLANK: begin
                if (cnt == CW'(BLANK_CYCLES - 1)) begin
                    nstate = SHOW;
                    ncnt   = '0;
                end else begin
                    ncnt = cnt + CW'(1);
                end
            end
            SHOW: begin
                if (cnt == CW'(DWELL_CYCLES - 1)) begin
                    nstate = BLANK;
                    ncnt   = '0;
                    if (idx == IW'(NUM_DIGITS - 1)) begin
                        nidx        = '0;
                        frame_start = 1'b1;
                        nfd         = 1'b1;
                    end else begin
                        nidx = idx + IW'(1);
                    end
                end else begin
                    ncnt = cnt + CW'(1);
                end
            end
            default: begin
                nstate = OFF;
                nidx   = '0;
                ncnt   = '0;
            end
        endcase
        if (!en) begin
            nstate      = OFF;
            nidx        = '0;
            ncnt        = '0;
            frame_start = 1'b0;
            nfd         = 1'b0;
        end
    end

    // A load coinciding with a frame start bypasses the pending buffer.
    always_comb begin
        npending = load ? value_in : pending;
        nactive  = frame_start ? npending : active;
        npv      = frame_start ? 1'b0 : (load | pend_valid);
    end

    // hi_zero[k]: nibbles k..NUM_DIGITS-1 of the next active value are all zero.
    always_comb begin
        hi_zero = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            hi_zero[k] = ((nactive >> (4 * k)) == '0);
        end
    end

    // Outputs are derived from the next state so the registers line up with it.
    always_comb begin
        nsel = '0;
        ndin = '0;
        nden = 1'b0;
        if (nstate == SHOW) begin
            nsel = NUM_DIGITS'(1) << nidx;
            ndin = nactive[4*nidx +: 4];
            nden = ~(lz_blank && (nidx != '0) && hi_zero[nidx]);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= OFF;
            idx        <= '0;
            cnt        <= '0;
            active     <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
            dec_in     <= '0;
            dec_enable <= 1'b0;
            digit_sel  <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= nstate;
            idx        <= nidx;
            cnt        <= ncnt;
            active     <= nactive;
            pending    <= npending;
            pend_valid <= npv;
            dec_in     <= ndin;
            dec_enable <= nden;
            digit_sel  <= nsel;
            frame_done <= nfd;
        end
    end

endmodule
